flu_wb_arbiter: RTL and testbench

Parametrised writeback merger for the execute stage's fixed-latency result port. It generalises the single shared ALU/branch/CSR/mult result mux to NrChannels independent producers. Each producer has a Depth-entry result queue. A round-robin arbiter drains the queues into the single scoreboard write port, and the block supports backpressure and flush. It sits between the functional units and the scoreboard writeback port.

---
 rtl/flu_wb_arbiter_pkg.sv | 29 ++
 rtl/flu_wb_queue.sv | 59 +++++
 rtl/flu_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_flu_wb_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/flu_wb_arbiter_pkg.sv
// Core-level types used by the fixed-latency writeback merger.
// Mirrors the ariane_pkg/riscv_pkg definitions it depends on, plus the merger entry type.
package flu_wb_arbiter_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned TRANS_ID_BITS      = 3;
    localparam int unsigned NR_FLU_WB_CHANNELS = 4;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } flu_wb_entry_t;

    // (base + off) mod n, for base < n and off <= n
    function automatic int unsigned wrap_inc(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/flu_wb_queue.sv
// Single-channel result FIFO: Depth entries, occupancy counter, synchronous flush.
// Pushing into a full queue or popping an empty one is the caller's error.
module flu_wb_queue #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   cnt_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr, r_rd;
    logic [CntW-1:0]  r_cnt;
    logic [PtrW-1:0]  w_wr_nxt, w_rd_nxt;

    assign w_wr_nxt = (r_wr == PtrW'(Depth - 1)) ? '0 : r_wr + PtrW'(1);
    assign w_rd_nxt = (r_rd == PtrW'(Depth - 1)) ? '0 : r_rd + PtrW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wr <= w_wr_nxt;
            if (pop_i)  r_rd <= w_rd_nxt;
            r_cnt <= r_cnt + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= data_i;
    end

    assign data_o  = r_mem[r_rd];
    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == '0);
    assign cnt_o   = r_cnt;

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
        !(pop_i && empty_o));
`endif

endmodule

// File: rtl/flu_wb_arbiter.sv
// Merges NrChannels fixed-latency producer queues into the single scoreboard writeback port
// with a round-robin grant that only advances on an accepted writeback.
module flu_wb_arbiter
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrChannels  = NR_FLU_WB_CHANNELS,
    parameter int unsigned Depth       = 2,
    parameter int unsigned DataWidth   = XLEN,
    parameter int unsigned TransIdBits = TRANS_ID_BITS
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic [NrChannels-1:0]                   ch_valid_i,
    output logic [NrChannels-1:0]                   ch_ready_o,
    input  logic [NrChannels-1:0][DataWidth-1:0]    ch_result_i,
    input  logic [NrChannels-1:0][TransIdBits-1:0]  ch_trans_id_i,
    input  exception_t [NrChannels-1:0]             ch_exception_i,
    output logic                                    wb_valid_o,
    input  logic                                    wb_ready_i,
    output logic [DataWidth-1:0]                    wb_result_o,
    output logic [TransIdBits-1:0]                  wb_trans_id_o,
    output exception_t                              wb_exception_o,
    output logic [$clog2(NrChannels)-1:0]           wb_channel_o,
    output logic                                    busy_o
);

    localparam int unsigned ChW  = $clog2(NrChannels);
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [DataWidth-1:0]   result;
        logic [TransIdBits-1:0] trans_id;
        exception_t             ex;
    } entry_t;

    logic                              r_rdy_en;
    logic [ChW-1:0]                    r_rr;
    logic [NrChannels-1:0]             w_push, w_pop, w_full, w_empty, w_nz;
    logic [NrChannels-1:0][CntW-1:0]   w_cnt;
    entry_t [NrChannels-1:0]           w_in, w_head;
    logic [NrChannels-1:0][ChW-1:0]    w_idx;
    logic [NrChannels-1:0]             w_hit, w_take;
    logic [NrChannels:0]               w_found;
    logic [NrChannels:0][ChW-1:0]      w_gacc;
    logic [ChW-1:0]                    w_grant, w_rr_nxt;
    logic                              w_any, w_fire;
    entry_t                            w_sel;

    // Ready is held low through reset and the release cycle so it stays a pure register output.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_rdy_en <= 1'b0;
        else         r_rdy_en <= 1'b1;
    end

    assign w_found[0] = 1'b0;
    assign w_gacc[0]  = '0;

    for (genvar g = 0; g < NrChannels; g++) begin : g_ch
        assign w_in[g]       = '{result: ch_result_i[g], trans_id: ch_trans_id_i[g],
                                 ex: ch_exception_i[g]};
        assign ch_ready_o[g] = r_rdy_en & ~w_full[g];
        assign w_push[g]     = ch_valid_i[g] & ch_ready_o[g] & ~flush_i;
        assign w_pop[g]      = w_fire & (w_grant == ChW'(g));
        assign w_nz[g]       = |w_cnt[g];

        flu_wb_queue #(
            .Depth (Depth),
            .Width ($bits(entry_t))
        ) u_queue (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (w_push[g]),
            .data_i  (w_in[g]),
            .pop_i   (w_pop[g]),
            .data_o  (w_head[g]),
            .full_o  (w_full[g]),
            .empty_o (w_empty[g]),
            .cnt_o   (w_cnt[g])
        );

        // Position g of the search order starting at r_rr; first hit wins.
        assign w_idx[g]       = ChW'(wrap_inc(32'(r_rr), g, NrChannels));
        assign w_hit[g]       = ~w_empty[w_idx[g]];
        assign w_take[g]      = w_hit[g] & ~w_found[g];
        assign w_found[g+1]   = w_found[g] | w_hit[g];
        assign w_gacc[g+1]    = w_gacc[g] | ({ChW{w_take[g]}} & w_idx[g]);
    end

    assign w_any    = w_found[NrChannels];
    assign w_grant  = w_gacc[NrChannels];
    assign w_sel    = w_head[w_grant];
    assign w_rr_nxt = ChW'(wrap_inc(32'(w_grant), 1, NrChannels));

    assign wb_valid_o = w_any & ~flush_i;
    assign w_fire     = wb_valid_o & wb_ready_i;
    assign busy_o     = |w_nz;

    always_comb begin
        wb_result_o    = '0;
        wb_trans_id_o  = '0;
        wb_exception_o = '0;
        wb_channel_o   = '0;
        if (wb_valid_o) begin
            wb_result_o    = w_sel.result;
            wb_trans_id_o  = w_sel.trans_id;
            wb_exception_o = w_sel.ex;
            wb_channel_o   = w_grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) r_rr <= '0;
        else if (w_fire)        r_rr <= w_rr_nxt;
    end

`ifndef SYNTHESIS
    a_wb_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wb_valid_o && !wb_ready_i && !flush_i) |=> (flush_i ||
            (wb_valid_o && $stable(wb_result_o) && $stable(wb_trans_id_o) &&
             $stable(wb_exception_o) && $stable(wb_channel_o))));

    for (genvar i = 0; i < NrChannels; i++) begin : g_dup_i
        for (genvar j = i + 1; j < NrChannels; j++) begin : g_dup_j
            a_dup_tid: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(!w_empty[i] && !w_empty[j] && (w_head[i].trans_id == w_head[j].trans_id)))
                else $warning("trans_id %0d queued on channels %0d and %0d",
                              w_head[i].trans_id, i, j);
        end
    end
`endif

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Directed bench for flu_wb_arbiter: reset, latency, round-robin, backpressure, flush, reset mid-drain.
module tb_flu_wb_arbiter;
    import flu_wb_arbiter_pkg::*;

    localparam int unsigned N = 4;

    logic                  clk = 1'b0;
    logic                  rst_n, flush, wb_ready;
    logic [N-1:0]          ch_valid, ch_ready;
    logic [N-1:0][63:0]    ch_result;
    logic [N-1:0][2:0]     ch_tid;
    exception_t [N-1:0]    ch_ex;
    logic                  wb_valid, busy;
    logic [63:0]           wb_result;
    logic [2:0]            wb_tid;
    exception_t            wb_ex;
    logic [1:0]            wb_chan;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    flu_wb_arbiter #(
        .NrChannels  (N),
        .Depth       (2),
        .DataWidth   (64),
        .TransIdBits (3)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .ch_valid_i     (ch_valid),
        .ch_ready_o     (ch_ready),
        .ch_result_i    (ch_result),
        .ch_trans_id_i  (ch_tid),
        .ch_exception_i (ch_ex),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_result_o    (wb_result),
        .wb_trans_id_o  (wb_tid),
        .wb_exception_o (wb_ex),
        .wb_channel_o   (wb_chan),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [63:0] res, input logic [2:0] tid);
        ch_valid[ch]  = 1'b1;
        ch_result[ch] = res;
        ch_tid[ch]    = tid;
    endtask

    task automatic idle_in();
        ch_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        ch_valid = '0; ch_result = '0; ch_tid = '0; ch_ex = '0;

        // reset and release
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(ch_ready), 64'h0);
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", wb_result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rel_ready", 64'(ch_ready), 64'hF);
        chk("rel_valid", 64'(wb_valid), 64'd0);

        // single push on ch2, one-cycle latency
        @(negedge clk);
        push(2'd2, 64'hDEAD, 3'd5);
        ch_ex[2].valid = 1'b1; ch_ex[2].cause = 64'd2;
        #1 chk("nobypass_valid", 64'(wb_valid), 64'd0);
        @(negedge clk); idle_in(); ch_ex = '0;
        #1;
        chk("one_valid", 64'(wb_valid), 64'd1);
        chk("one_result", wb_result, 64'hDEAD);
        chk("one_tid", 64'(wb_tid), 64'd5);
        chk("one_chan", 64'(wb_chan), 64'd2);
        chk("one_exvalid", 64'(wb_ex.valid), 64'd1);
        chk("one_excause", wb_ex.cause, 64'd2);
        chk("one_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        chk("one_after_valid", 64'(wb_valid), 64'd0);
        chk("one_after_result", wb_result, 64'd0);
        chk("one_after_chan", 64'(wb_chan), 64'd0);
        chk("one_after_busy", 64'(busy), 64'd0);

        // flush an idle block to bring the pointer back to 0
        @(negedge clk); flush = 1'b1;
        #1 chk("idleflush_valid", 64'(wb_valid), 64'd0);

        // all four channels in one cycle: drained 0,1,2,3
        @(negedge clk); flush = 1'b0;
        for (int k = 0; k < 4; k++) push(2'(k), 64'(100 + k), 3'(k));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); idle_in();
            #1;
            chk("rr_chan", 64'(wb_chan), 64'(k));
            chk("rr_tid", 64'(wb_tid), 64'(k));
            chk("rr_result", wb_result, 64'(100 + k));
        end
        @(negedge clk); #1;
        chk("rr_drained_valid", 64'(wb_valid), 64'd0);
        chk("rr_drained_busy", 64'(busy), 64'd0);
        push(2'd1, 64'h11, 3'd6); push(2'd3, 64'h33, 3'd7);
        @(negedge clk); idle_in();
        #1 chk("rr_wrap_first", 64'(wb_chan), 64'd1);
        @(negedge clk);
        #1 chk("rr_wrap_second", 64'(wb_chan), 64'd3);
        @(negedge clk);
        #1 chk("rr_wrap_idle", 64'(wb_valid), 64'd0);

        // backpressure: ch1 fills at Depth=2, third push refused
        wb_ready = 1'b0;
        push(2'd1, 64'hA1, 3'd1);
        #1 chk("bp_ready_p1", 64'(ch_ready[1]), 64'd1);
        @(negedge clk); push(2'd1, 64'hA2, 3'd2);
        #1;
        chk("bp_ready_p2", 64'(ch_ready[1]), 64'd1);
        chk("bp_valid_p2", 64'(wb_valid), 64'd1);
        chk("bp_result_p2", wb_result, 64'hA1);
        @(negedge clk); push(2'd1, 64'hA3, 3'd3);
        #1;
        chk("bp_ready_full", 64'(ch_ready[1]), 64'd0);
        chk("bp_result_p3", wb_result, 64'hA1);
        chk("bp_tid_p3", 64'(wb_tid), 64'd1);
        @(negedge clk); idle_in();
        #1;
        chk("bp_ready_hold", 64'(ch_ready[1]), 64'd0);
        chk("bp_result_hold", wb_result, 64'hA1);
        @(negedge clk); wb_ready = 1'b1;
        #1 chk("bp_pop1_result", wb_result, 64'hA1);
        @(negedge clk); #1;
        chk("bp_ready_after_pop", 64'(ch_ready[1]), 64'd1);
        chk("bp_pop2_result", wb_result, 64'hA2);
        chk("bp_pop2_tid", 64'(wb_tid), 64'd2);
        @(negedge clk); #1;
        chk("bp_third_dropped", 64'(wb_valid), 64'd0);
        chk("bp_busy", 64'(busy), 64'd0);

        // flush with three entries queued and a concurrent push
        wb_ready = 1'b0;
        push(2'd0, 64'hF0, 3'd1); push(2'd2, 64'hF2, 3'd2);
        @(negedge clk); idle_in(); push(2'd3, 64'hF3, 3'd3);
        #1 chk("fl_pre_chan", 64'(wb_chan), 64'd2);
        @(negedge clk); idle_in(); flush = 1'b1; push(2'd0, 64'hF4, 3'd4);
        #1;
        chk("fl_valid", 64'(wb_valid), 64'd0);
        chk("fl_busy_during", 64'(busy), 64'd1);
        @(negedge clk); idle_in(); flush = 1'b0; wb_ready = 1'b1;
        #1;
        chk("fl_busy_after", 64'(busy), 64'd0);
        chk("fl_ready_after", 64'(ch_ready), 64'hF);
        chk("fl_valid_after", 64'(wb_valid), 64'd0);
        @(negedge clk);
        #1 chk("fl_push_dropped", 64'(wb_valid), 64'd0);
        push(2'd1, 64'h21, 3'd1); push(2'd3, 64'h23, 3'd3);
        @(negedge clk); idle_in();
        #1 chk("fl_rr_zero", 64'(wb_chan), 64'd1);
        @(negedge clk);
        #1 chk("fl_rr_next", 64'(wb_chan), 64'd3);
        @(negedge clk);
        #1 chk("fl_idle", 64'(wb_valid), 64'd0);

        // reset in the middle of a drain
        wb_ready = 1'b0;
        push(2'd0, 64'hC0, 3'd1); push(2'd1, 64'hC1, 3'd2);
        @(negedge clk); idle_in(); wb_ready = 1'b1;
        #1;
        chk("mr_valid", 64'(wb_valid), 64'd1);
        chk("mr_chan0", 64'(wb_chan), 64'd0);
        chk("mr_result0", wb_result, 64'hC0);
        @(negedge clk); rst_n = 1'b0;
        #1 chk("mr_result1", wb_result, 64'hC1);
        @(negedge clk); #1;
        chk("mr_rst_valid", 64'(wb_valid), 64'd0);
        chk("mr_rst_busy", 64'(busy), 64'd0);
        chk("mr_rst_ready", 64'(ch_ready), 64'h0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mr_rel_ready", 64'(ch_ready), 64'hF);
        chk("mr_rel_valid", 64'(wb_valid), 64'd0);
        @(negedge clk); #1;
        chk("mr_no_reappear", 64'(wb_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
